acc_quant_pack: RTL and testbench

Downstream neighbour of the pipelined accumulator. It consumes each finished accumulation (I_result / I_result_rdy) and applies a bias add, a rounding arithmetic right shift, optional ReLU and signed saturation to C_OUT bits. It packs C_PACK quantised lanes into one output word and buffers the words in a small FIFO for the ofmap buffer writer. The input side cannot be stalled, so the block exports level, almost-full and overflow status to the controller.

---
 rtl/cnna_pkg.sv | 31 +++
 rtl/sfifo_fwft.sv | 77 +++++++
 rtl/acc_quant_pack.sv | 178 +++++++++++++++++
 tb/tb_acc_quant_pack.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cnna_pkg.sv
// Shared constants and helpers for the CNN accelerator datapath blocks
// (accumulator, quantise/pack stage, ofmap buffer writer).
package cnna_pkg;

    localparam int CNNA_OUT_W = 8;
    localparam int CNNA_PACK  = 4;

    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        while ((1 << bits) < value) bits++;
        return bits;
    endfunction

    function automatic int sat_max(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    function automatic int sat_min(input int width);
        return -(1 << (width - 1));
    endfunction

    localparam int CNNA_SAT_MAX = sat_max(CNNA_OUT_W);
    localparam int CNNA_SAT_MIN = sat_min(CNNA_OUT_W);

    typedef struct packed {
        logic vld;
        logic last;
    } beat_ctrl_t;

endpackage

// File: rtl/sfifo_fwft.sv
// Synchronous first-word-fall-through FIFO with registered occupancy,
// almost-full and a sticky overflow flag for writes that hit a full FIFO.
module sfifo_fwft
    import cnna_pkg::*;
#(
    parameter int WIDTH = 36,
    parameter int DEPTH = 8
) (
    input  logic                    I_clk,
    input  logic                    I_rst,
    input  logic                    I_wr_en,
    input  logic [WIDTH-1:0]        I_wr_data,
    output logic [WIDTH-1:0]        O_rd_data,
    output logic                    O_rd_vld,
    input  logic                    I_rd_en,
    output logic [clog2(DEPTH):0]   O_level,
    output logic                    O_almost_full,
    output logic                    O_overflow
);

    localparam int AW = clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic [LW-1:0]    level_next;
    logic             almost_full;
    logic             overflow;
    logic             empty;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = !empty && I_rd_en;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    assign do_push = I_wr_en && (!full || do_pop);

    always_comb begin
        level_next = level;
        if (do_push && !do_pop) begin
            level_next = level + LW'(1);
        end else if (!do_push && do_pop) begin
            level_next = level - LW'(1);
        end
    end

    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level       <= level_next;
            almost_full <= (level_next >= LW'(DEPTH - 2));
            if (I_wr_en && !do_push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge I_clk) begin
        if (do_push) mem[wr_ptr] <= I_wr_data;
    end

    assign O_rd_vld      = !empty;
    assign O_rd_data     = empty ? '0 : mem[rd_ptr];
    assign O_level       = level;
    assign O_almost_full = almost_full;
    assign O_overflow    = overflow;

endmodule

// File: rtl/acc_quant_pack.sv
// Quantises finished accumulations (bias, rounding shift, ReLU, saturation),
// packs C_PACK lanes per word and buffers the words for the ofmap writer.
module acc_quant_pack
    import cnna_pkg::*;
#(
    parameter int C_IN      = 13,
    parameter int C_BIAS    = 16,
    parameter int C_SHIFT_W = 5,
    parameter int C_OUT     = CNNA_OUT_W,
    parameter int C_PACK    = CNNA_PACK,
    parameter int C_DEPTH   = 8
) (
    input  logic                        I_clk,
    input  logic                        I_rst,
    input  logic signed [C_IN-1:0]      I_result,
    input  logic                        I_result_rdy,
    input  logic                        I_result_last,
    input  logic signed [C_BIAS-1:0]    I_bias,
    input  logic [C_SHIFT_W-1:0]        I_shift,
    input  logic                        I_relu_en,
    output logic [C_PACK*C_OUT-1:0]     O_data,
    output logic [C_PACK-1:0]           O_keep,
    output logic                        O_data_vld,
    input  logic                        I_data_rdy,
    output logic [clog2(C_DEPTH):0]     O_level,
    output logic                        O_almost_full,
    output logic                        O_overflow
);

    localparam int W      = ((C_IN > C_BIAS) ? C_IN : C_BIAS) + 1;
    localparam int LANE_W = (C_PACK > 1) ? clog2(C_PACK) : 1;
    localparam int DW     = C_PACK * C_OUT;
    localparam logic signed [W:0] LANE_MAX = (W+1)'(sat_max(C_OUT));
    localparam logic signed [W:0] LANE_MIN = (W+1)'(sat_min(C_OUT));

    beat_ctrl_t              s1_ctrl;
    beat_ctrl_t              s2_ctrl;
    beat_ctrl_t              s3_ctrl;
    logic signed [W-1:0]     s1_sum;
    logic [C_SHIFT_W-1:0]    s1_shift;
    logic                    s1_relu;
    logic                    s2_relu;
    logic signed [W:0]       s1_wide;
    logic signed [W:0]       rnd;
    logic signed [W:0]       s2_next;
    logic signed [W:0]       s2_val;
    logic signed [C_OUT-1:0] s3_next;
    logic signed [C_OUT-1:0] s3_val;

    logic [LANE_W-1:0]       lane;
    logic [DW-1:0]           word_q;
    logic [DW-1:0]           word_next;
    logic [C_PACK-1:0]       keep_next;
    logic                    word_done;
    logic                    push_vld;
    logic [DW-1:0]           push_data;
    logic [C_PACK-1:0]       push_keep;
    logic [DW+C_PACK-1:0]    fifo_rd_data;

    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            s1_ctrl  <= '0;
            s1_sum   <= '0;
            s1_shift <= '0;
            s1_relu  <= 1'b0;
        end else begin
            s1_ctrl.vld  <= I_result_rdy;
            s1_ctrl.last <= I_result_rdy && I_result_last;
            if (I_result_rdy) begin
                s1_sum   <= W'(I_result) + W'(I_bias);
                s1_shift <= I_shift;
                s1_relu  <= I_relu_en;
            end
        end
    end

    // Half-up rounding; very large shifts collapse to the sign fill directly
    // because the rounding constant would no longer fit the widened adder.
    always_comb begin
        s1_wide = (W+1)'(s1_sum);
        rnd     = '0;
        s2_next = s1_wide;
        if (int'(s1_shift) >= W) begin
            s2_next = {(W+1){s1_sum[W-1]}};
        end else if (s1_shift != '0) begin
            rnd     = (W+1)'(1) << (s1_shift - C_SHIFT_W'(1));
            s2_next = (s1_wide + rnd) >>> s1_shift;
        end
    end

    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            s2_ctrl <= '0;
            s2_val  <= '0;
            s2_relu <= 1'b0;
        end else begin
            s2_ctrl <= s1_ctrl;
            s2_val  <= s2_next;
            s2_relu <= s1_relu;
        end
    end

    always_comb begin
        s3_next = s2_val[C_OUT-1:0];
        if (s2_relu && s2_val[W]) begin
            s3_next = '0;
        end else if (s2_val > LANE_MAX) begin
            s3_next = C_OUT'(LANE_MAX);
        end else if (s2_val < LANE_MIN) begin
            s3_next = C_OUT'(LANE_MIN);
        end
    end

    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            s3_ctrl <= '0;
            s3_val  <= '0;
        end else begin
            s3_ctrl <= s2_ctrl;
            s3_val  <= s3_next;
        end
    end

    always_comb begin
        word_next = word_q;
        keep_next = '0;
        for (int i = 0; i < C_PACK; i++) begin
            if (LANE_W'(i) == lane) word_next[i*C_OUT +: C_OUT] = s3_val;
            if (LANE_W'(i) <= lane) keep_next[i] = 1'b1;
        end
    end

    assign word_done = s3_ctrl.vld && (s3_ctrl.last || (lane == LANE_W'(C_PACK - 1)));

    // The finished word is held one cycle in push_* before entering the FIFO.
    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            lane      <= '0;
            word_q    <= '0;
            push_vld  <= 1'b0;
            push_data <= '0;
            push_keep <= '0;
        end else begin
            push_vld <= word_done;
            if (s3_ctrl.vld) begin
                if (word_done) begin
                    push_data <= word_next;
                    push_keep <= keep_next;
                    word_q    <= '0;
                    lane      <= '0;
                end else begin
                    word_q <= word_next;
                    lane   <= lane + LANE_W'(1);
                end
            end
        end
    end

    sfifo_fwft #(
        .WIDTH (DW + C_PACK),
        .DEPTH (C_DEPTH)
    ) u_fifo (
        .I_clk         (I_clk),
        .I_rst         (I_rst),
        .I_wr_en       (push_vld),
        .I_wr_data     ({push_keep, push_data}),
        .O_rd_data     (fifo_rd_data),
        .O_rd_vld      (O_data_vld),
        .I_rd_en       (I_data_rdy),
        .O_level       (O_level),
        .O_almost_full (O_almost_full),
        .O_overflow    (O_overflow)
    );

    assign O_data = fifo_rd_data[DW-1:0];
    assign O_keep = fifo_rd_data[DW+C_PACK-1:DW];

endmodule

// File: tb/tb_acc_quant_pack.sv
// Directed bench for acc_quant_pack: quantisation corner cases, packing,
// FIFO fill/overflow/drain and asynchronous reset, with hand-computed words.
module tb_acc_quant_pack;

    localparam int C_IN      = 13;
    localparam int C_BIAS    = 16;
    localparam int C_SHIFT_W = 5;
    localparam int C_OUT     = 8;
    localparam int C_PACK    = 4;
    localparam int C_DEPTH   = 8;

    logic                      I_clk = 1'b0;
    logic                      I_rst;
    logic [C_IN-1:0]           I_result;
    logic                      I_result_rdy;
    logic                      I_result_last;
    logic [C_BIAS-1:0]         I_bias;
    logic [C_SHIFT_W-1:0]      I_shift;
    logic                      I_relu_en;
    logic [C_PACK*C_OUT-1:0]   O_data;
    logic [C_PACK-1:0]         O_keep;
    logic                      O_data_vld;
    logic                      I_data_rdy;
    logic [3:0]                O_level;
    logic                      O_almost_full;
    logic                      O_overflow;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    always #5 I_clk = ~I_clk;

    acc_quant_pack #(
        .C_IN      (C_IN),
        .C_BIAS    (C_BIAS),
        .C_SHIFT_W (C_SHIFT_W),
        .C_OUT     (C_OUT),
        .C_PACK    (C_PACK),
        .C_DEPTH   (C_DEPTH)
    ) dut (
        .I_clk         (I_clk),
        .I_rst         (I_rst),
        .I_result      (I_result),
        .I_result_rdy  (I_result_rdy),
        .I_result_last (I_result_last),
        .I_bias        (I_bias),
        .I_shift       (I_shift),
        .I_relu_en     (I_relu_en),
        .O_data        (O_data),
        .O_keep        (O_keep),
        .O_data_vld    (O_data_vld),
        .I_data_rdy    (I_data_rdy),
        .O_level       (O_level),
        .O_almost_full (O_almost_full),
        .O_overflow    (O_overflow)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assert_cnt++;
        if (actual !== expected) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int res, input int bias, input int shift, input bit relu, input bit last);
        @(negedge I_clk);
        I_result      = C_IN'(res);
        I_bias        = C_BIAS'(bias);
        I_shift       = C_SHIFT_W'(shift);
        I_relu_en     = relu;
        I_result_last = last;
        I_result_rdy  = 1'b1;
    endtask

    task automatic endStimulus();
        @(negedge I_clk);
        I_result_rdy  = 1'b0;
        I_result_last = 1'b0;
    endtask

    task automatic popWord(input string tag, input logic [31:0] exp_data, input logic [31:0] exp_keep);
        int waited = 0;
        while (!O_data_vld && waited < 20) begin
            @(negedge I_clk);
            waited++;
        end
        checkOutput({tag, "_vld"}, 32'(O_data_vld), 32'd1);
        checkOutput({tag, "_data"}, O_data, exp_data);
        checkOutput({tag, "_keep"}, 32'(O_keep), exp_keep);
        I_data_rdy = 1'b1;
        @(negedge I_clk);
        I_data_rdy = 1'b0;
    endtask

    function automatic logic [31:0] fill_word(input int k);
        return {8'(k*8 + 3), 8'(k*8 + 2), 8'(k*8 + 1), 8'(k*8)};
    endfunction

    // Sends one full word and returns on the negedge right after its FIFO write;
    // with_pop raises I_data_rdy exactly on the push edge.
    task automatic sendWord(input int k, input bit with_pop);
        for (int i = 0; i < 4; i++) applyStimulus(k*8 + i, 0, 0, 1'b0, 1'b0);
        endStimulus();
        @(negedge I_clk);
        @(negedge I_clk);
        @(negedge I_clk);
        if (with_pop) I_data_rdy = 1'b1;
        @(negedge I_clk);
        I_data_rdy = 1'b0;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_data"}, O_data, 32'h0);
        checkOutput({tag, "_keep"}, 32'(O_keep), 32'h0);
        checkOutput({tag, "_vld"}, 32'(O_data_vld), 32'h0);
        checkOutput({tag, "_level"}, 32'(O_level), 32'h0);
        checkOutput({tag, "_afull"}, 32'(O_almost_full), 32'h0);
        checkOutput({tag, "_ovf"}, 32'(O_overflow), 32'h0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        I_rst = 1'b0;
        I_result = '0;
        I_result_rdy = 1'b0;
        I_result_last = 1'b0;
        I_bias = '0;
        I_shift = '0;
        I_relu_en = 1'b0;
        I_data_rdy = 1'b0;
        #12;
        checkIdleOutputs("reset");
        @(negedge I_clk);
        I_rst = 1'b1;
        @(negedge I_clk);

        $display("[TB] full word and latency");
        for (int i = 0; i < 4; i++) applyStimulus(100, 28, 2, 1'b0, 1'b0);
        endStimulus();
        for (int k = 1; k <= 3; k++) begin
            @(negedge I_clk);
            checkOutput($sformatf("t1_early_vld_%0d", k), 32'(O_data_vld), 32'd0);
        end
        @(negedge I_clk);
        checkOutput("t1_vld_at_4", 32'(O_data_vld), 32'd1);
        popWord("t1", 32'h20202020, 32'hF);

        $display("[TB] saturation and relu");
        applyStimulus(4095, 1000, 0, 1'b0, 1'b0);
        applyStimulus(4095, 1000, 0, 1'b1, 1'b0);
        applyStimulus(-4096, -1000, 0, 1'b0, 1'b0);
        applyStimulus(-4096, -1000, 0, 1'b1, 1'b0);
        endStimulus();
        popWord("t2", 32'h00807F7F, 32'hF);

        $display("[TB] rounding");
        applyStimulus(-3, 0, 1, 1'b0, 1'b0);
        applyStimulus(-5, 0, 1, 1'b0, 1'b0);
        applyStimulus(3, 0, 1, 1'b0, 1'b0);
        applyStimulus(100, 0, 31, 1'b0, 1'b0);
        endStimulus();
        popWord("t3", 32'h0002FEFF, 32'hF);

        $display("[TB] partial row");
        applyStimulus(1, 0, 0, 1'b0, 1'b0);
        applyStimulus(2, 0, 0, 1'b0, 1'b1);
        endStimulus();
        popWord("t4a", 32'h00000201, 32'h3);
        applyStimulus(7, 0, 0, 1'b0, 1'b1);
        endStimulus();
        popWord("t4b", 32'h00000007, 32'h1);

        $display("[TB] backpressure fill, overflow, drain");
        for (int k = 0; k < 8; k++) begin
            sendWord(k, 1'b0);
            checkOutput($sformatf("t5_fill%0d_level", k), 32'(O_level), 32'(k + 1));
            checkOutput($sformatf("t5_fill%0d_afull", k), 32'(O_almost_full), (k + 1 >= 6) ? 32'd1 : 32'd0);
        end
        sendWord(8, 1'b1);
        checkOutput("t5_pushpop_full_level", 32'(O_level), 32'd8);
        checkOutput("t5_pushpop_full_ovf", 32'(O_overflow), 32'd0);
        sendWord(9, 1'b0);
        checkOutput("t5_drop_level", 32'(O_level), 32'd8);
        checkOutput("t5_drop_ovf", 32'(O_overflow), 32'd1);
        I_data_rdy = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            checkOutput($sformatf("t5_drain%0d_vld", j), 32'(O_data_vld), 32'd1);
            checkOutput($sformatf("t5_drain%0d_data", j), O_data, fill_word(j));
            @(negedge I_clk);
        end
        I_data_rdy = 1'b0;
        checkOutput("t5_drained_vld", 32'(O_data_vld), 32'd0);
        checkOutput("t5_drained_level", 32'(O_level), 32'd0);
        checkOutput("t5_drained_ovf", 32'(O_overflow), 32'd1);

        $display("[TB] reset mid-operation");
        for (int k = 0; k < 3; k++) sendWord(k, 1'b0);
        applyStimulus(50, 0, 0, 1'b0, 1'b0);
        applyStimulus(60, 0, 0, 1'b0, 1'b0);
        endStimulus();
        repeat (4) @(negedge I_clk);
        checkOutput("t6_pre_level", 32'(O_level), 32'd3);
        #2;
        I_rst = 1'b0;
        #1;
        checkIdleOutputs("t6_async");
        @(negedge I_clk);
        I_rst = 1'b1;
        for (int i = 1; i <= 4; i++) applyStimulus(i, 0, 0, 1'b0, 1'b0);
        endStimulus();
        repeat (4) @(negedge I_clk);
        checkOutput("t6_level", 32'(O_level), 32'd1);
        popWord("t6", 32'h04030201, 32'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
